// File: rtl/alu_sequencer.sv
// Multi-cycle add/sub/mul/div sequencer sharing one adder, with a busy/done handshake.
// Define ALU_SEQ_DIV_EN to build the restoring divider; otherwise op 3 reports error.
module alu_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] remainder,
  output logic             error
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDSUB = 3'd1,
    MUL    = 3'd2,
    DIV    = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_next;

  // x: addend / multiplicand / divisor; y: addend / multiplier / dividend-quotient;
  // acc: product accumulator / partial remainder
  logic [WIDTH-1:0] x, x_next;
  logic [WIDTH-1:0] y, y_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [CW-1:0]    count, count_next;
  logic [1:0]       op_reg, op_next;
  logic [WIDTH-1:0] result_next, remainder_next;
  logic             error_next;

  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             add_sub;
`ifdef ALU_SEQ_DIV_EN
  logic             carry;
  logic             take;
`endif

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    case (state)
      ADDSUB: begin
        add_a   = x;
        add_b   = y;
        add_sub = (op_reg == 2'd1);
      end
      MUL: begin
        add_a = acc;
        add_b = x;
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: begin
        add_a   = {acc[WIDTH-2:0], y[WIDTH-1]};
        add_b   = x;
        add_sub = 1'b1;
      end
`endif
      default: ;
    endcase
  end

`ifdef ALU_SEQ_DIV_EN
  assign {carry, sum} = {1'b0, add_a} + {1'b0, add_b ^ {WIDTH{add_sub}}} + (WIDTH+1)'(add_sub);
`else
  assign sum = add_a + (add_b ^ {WIDTH{add_sub}}) + WIDTH'(add_sub);
`endif

  always_comb begin
    state_next     = state;
    x_next         = x;
    y_next         = y;
    acc_next       = acc;
    count_next     = count;
    op_next        = op_reg;
    result_next    = result;
    remainder_next = remainder;
    error_next     = error;
`ifdef ALU_SEQ_DIV_EN
    take           = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && !clear) begin
          op_next    = op;
          acc_next   = '0;
          count_next = '0;
          // Divider keeps the divisor in x and shifts the dividend through y
          if (op == 2'd3) begin
            x_next = operand_b;
            y_next = operand_a;
          end else begin
            x_next = operand_a;
            y_next = operand_b;
          end
          case (op)
            2'd2:    state_next = MUL;
`ifdef ALU_SEQ_DIV_EN
            2'd3:    state_next = DIV;
`endif
            default: state_next = ADDSUB;
          endcase
        end
      end
      ADDSUB: begin
        result_next    = sum;
        remainder_next = '0;
        error_next     = 1'b0;
`ifndef ALU_SEQ_DIV_EN
        if (op_reg == 2'd3) begin
          result_next = '0;
          error_next  = 1'b1;
        end
`endif
        state_next = DONE;
      end
      MUL: begin
        if (y[0]) acc_next = sum;
        x_next     = x << 1;
        y_next     = y >> 1;
        count_next = count + CW'(1);
        if (count == LAST) begin
          result_next    = acc_next;
          remainder_next = '0;
          error_next     = 1'b0;
          state_next     = DONE;
        end
      end
`ifdef ALU_SEQ_DIV_EN
      DIV: begin
        if (count == '0 && x == '0) begin
          result_next    = '1;
          remainder_next = y;
          error_next     = 1'b1;
          state_next     = DONE;
        end else begin
          // A set top bit means the shifted remainder exceeds any WIDTH-bit divisor
          take       = acc[WIDTH-1] | carry;
          acc_next   = take ? sum : add_a;
          y_next     = {y[WIDTH-2:0], take};
          count_next = count + CW'(1);
          if (count == LAST) begin
            result_next    = y_next;
            remainder_next = acc_next;
            error_next     = 1'b0;
            state_next     = DONE;
          end
        end
      end
`endif
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clear) begin
      state_next     = IDLE;
      result_next    = '0;
      remainder_next = '0;
      error_next     = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x         <= '0;
      y         <= '0;
      acc       <= '0;
      count     <= '0;
      op_reg    <= '0;
      result    <= '0;
      remainder <= '0;
      error     <= 1'b0;
    end else begin
      x         <= x_next;
      y         <= y_next;
      acc       <= acc_next;
      count     <= count_next;
      op_reg    <= op_next;
      result    <= result_next;
      remainder <= remainder_next;
      error     <= error_next;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer against an arithmetic reference model.
// Follows ALU_SEQ_DIV_EN so the expected op-3 behaviour matches the build.
module tb_alu_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        busy, done, error;
  logic [31:0] result, remainder;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .clear(clear), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .busy(busy), .done(done),
    .result(result), .remainder(remainder), .error(error)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [31:0] rm, output logic e,
                       output int lat);
    logic [63:0] p;
    rm  = '0;
    e   = 1'b0;
    lat = 1;
    case (o)
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin
        p   = 64'(a) * 64'(b);
        r   = p[31:0];
        lat = 32;
      end
      default: begin
`ifdef ALU_SEQ_DIV_EN
        if (b == 0) begin
          r  = 32'hFFFF_FFFF;
          rm = a;
          e  = 1'b1;
        end else begin
          r   = a / b;
          rm  = a % b;
          lat = 32;
        end
`else
        r = '0;
        e = 1'b1;
`endif
      end
    endcase
  endtask

  // Called at a negedge with the DUT idle; returns at the first idle negedge afterwards
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise);
    logic [31:0] er, erm;
    logic        ee;
    int          lat, k;
    model(o, a, b, er, erm, ee, lat);
    op = o; operand_a = a; operand_b = b; start = 1'b1;
    @(negedge clock);
    start = 1'b0; op = 2'($urandom); operand_a = $urandom; operand_b = $urandom;
    check($sformatf("op%0d_busy_after_accept", o), 64'(busy), 64'(1));
    k = 0;
    while (!done && k < 100) begin
      if (noise) begin
        start = 1'($urandom); op = 2'($urandom);
        operand_a = $urandom; operand_b = $urandom;
      end
      @(negedge clock);
      k++;
    end
    start = 1'b0;
    check($sformatf("op%0d_latency", o), 64'(k), 64'(lat));
    check($sformatf("op%0d_result a=%0h b=%0h", o, a, b), 64'(result), 64'(er));
    check($sformatf("op%0d_remainder", o), 64'(remainder), 64'(erm));
    check($sformatf("op%0d_error", o), 64'(error), 64'(ee));
    @(negedge clock);
    check($sformatf("op%0d_idle_busy", o), 64'(busy), 64'(0));
    check($sformatf("op%0d_idle_done", o), 64'(done), 64'(0));
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic        seen_done;

    repeat (3) @(negedge clock);
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_result", 64'(result), 64'(0));
    check("reset_remainder", 64'(remainder), 64'(0));
    check("reset_error", 64'(error), 64'(0));
    reset = 1'b1;
    @(negedge clock);

    run_op(2'd0, 32'd7, 32'd5, 1'b0);
    run_op(2'd1, 32'd3, 32'd5, 1'b0);
    run_op(2'd2, 32'd1234, 32'd5678, 1'b0);
    check("mul_1234x5678_const", 64'(result), 64'd7006652);
    run_op(2'd2, 32'h10000, 32'h10000, 1'b0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
`ifdef ALU_SEQ_DIV_EN
    check("div_100_7_const", 64'(result), 64'd14);
`else
    check("div_off_const", 64'(error), 64'd1);
`endif
    run_op(2'd3, 32'd9, 32'd0, 1'b0);
    run_op(2'd2, 32'd1234, 32'd5678, 1'b1);

    // Reset pulled mid-multiply after edge 10
    op = 2'd2; operand_a = 32'd1234; operand_b = 32'd5678; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_mid_busy", 64'(busy), 64'(0));
    check("rst_mid_result", 64'(result), 64'(0));
    check("rst_mid_done", 64'(done), 64'(0));
    @(negedge clock);
    reset = 1'b1;
    run_op(2'd0, 32'd7, 32'd5, 1'b0);

    // Clear after edge 15 of a long operation
`ifdef ALU_SEQ_DIV_EN
    op = 2'd3;
`else
    op = 2'd2;
`endif
    operand_a = 32'd100; operand_b = 32'd7; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    seen_done = 1'b0;
    repeat (14) begin
      @(negedge clock);
      seen_done |= done;
    end
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    seen_done |= done;
    check("clear_long_busy", 64'(busy), 64'(0));
    check("clear_long_result", 64'(result), 64'(0));
    check("clear_long_remainder", 64'(remainder), 64'(0));
    check("clear_long_error", 64'(error), 64'(0));
    check("clear_long_no_done", 64'(seen_done), 64'(0));

    // Clear together with start in IDLE drops the request
    run_op(2'd0, 32'd7, 32'd5, 1'b0);
    op = 2'd2; start = 1'b1; clear = 1'b1;
    @(negedge clock);
    start = 1'b0; clear = 1'b0;
    check("clear_start_busy", 64'(busy), 64'(0));
    check("clear_start_result", 64'(result), 64'(0));

    // Clear during the done cycle
    op = 2'd0; operand_a = 32'd1; operand_b = 32'd2; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("done_cycle_done", 64'(done), 64'(1));
    check("done_cycle_result", 64'(result), 64'(3));
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clear_done_busy", 64'(busy), 64'(0));
    check("clear_done_done", 64'(done), 64'(0));
    check("clear_done_result", 64'(result), 64'(0));

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom);
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(3) == 0) rb = 32'($urandom_range(7));
      run_op(ro, ra, rb, 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle arithmetic sequencer for the calculator datapath. Accepts a latched operand pair and a 2-bit ALU op code from the calculator control unit. Executes add/sub in one cycle, and unsigned multiply/divide as 32-step shift-add and restoring-division iterations over a single shared 32-bit adder. Returns the result with a busy/done handshake, so the control unit no longer needs combinational `*` and `/`.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`.

Ports:
- `clock`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous abort (CLEAR button); wins over `start`.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  0 add, 1 sub, 2 mul, 3 div.
- `operand_a`  in  WIDTH  first operand (operandF).
- `operand_b`  in  WIDTH  second operand (operandS).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse; result valid.
- `result`  out  WIDTH  sum/difference/product (low WIDTH bits)/quotient.
- `remainder`  out  WIDTH  division remainder; 0 for other ops.
- `error`  out  1  divide-by-zero (or div with divider compiled out).

## Operation
- One clock; reset is asynchronous and active-low.
- States: IDLE, ADDSUB, MUL, DIV, DONE (one-hot or binary, implementer's choice).
- IDLE: on `start`=1 and `clear`=0, latch `operand_a`, `operand_b` and `op`, clear the iteration counter, and go to ADDSUB (op 0/1), MUL (op 2) or DIV (op 3).
- ADDSUB: `result` = a+b or a−b modulo 2^WIDTH, `remainder`=0, `error`=0; then go to DONE.
- MUL: unsigned shift-add. Per step, if multiplier LSB is 1 then acc += multiplicand; multiplicand <<1, multiplier >>1. After WIDTH steps, `result`=acc (low WIDTH bits, overflow discarded), `remainder`=0; go to DONE.
- DIV: unsigned restoring division, one quotient bit per step, MSB first. After WIDTH steps, `result`=quotient and `remainder`=remainder; go to DONE.
- Divide by zero: detected in the first DIV cycle. `result`=all ones, `remainder`=operand_a, `error`=1; go to DONE without iterating.
- DONE: `done`=1 for exactly this cycle; then go to IDLE. `start` is ignored.
- `start` is ignored in all states except IDLE. Operand inputs are don't-care after acceptance.
- `result`, `remainder` and `error` hold their values until the next completion, clear or reset.
- `clear`=1 in any state: IDLE at the next edge, `result`/`remainder`/`error` are zeroed, no `done`.
- `reset` low: immediately IDLE, all outputs and internal registers 0.

## Timing
- Edge 0 is the rising edge where `start` is accepted; `busy`=1 after edge 0.
- ADD/SUB: outputs update and `done`=1 after edge 1; IDLE after edge 2. Latency 1.
- MUL/DIV: steps occur at edges 1..WIDTH; outputs update and `done`=1 after edge WIDTH; IDLE after edge WIDTH+1.
- Div-by-zero: outputs update and `done`=1 after edge 1.
- Earliest back-to-back `start`: the edge after `done` falls, i.e. the first IDLE cycle.
- `start` and `clear` together in IDLE: `clear` wins, request dropped.
- `clear` in the same cycle as `done`: transition to IDLE, outputs zeroed.

## Configuration
- `ALU_SEQ_DIV_EN` defined: DIV state and restoring divider are compiled in, behaving as above.
- Undefined: no divider logic is built. Op 3 goes to DONE after edge 1 with `result`=0, `remainder`=0, `error`=1. Add/sub/mul are unchanged.

## Test plan
- Reset low mid-MUL (edge 10) → `busy`=0, `result`=0 immediately; `start` accepted on the first edge after reset releases.
- add 7+5 → `done` after edge 1, `result`=12; sub 3−5 → `result`=32'hFFFFFFFE, `error`=0.
- mul 1234×5678 → `done` after edge 32, `result`=7006652; mul 32'h10000×32'h10000 → `result`=0.
- div 100/7 (macro on) → `done` after edge 32, `result`=14, `remainder`=2; div 9/0 → `done` after edge 1, `result`=32'hFFFFFFFF, `error`=1.
- `start` pulsed during MUL busy → ignored, original product returned. `clear` at edge 15 of DIV → IDLE, outputs 0, no `done`.
- Macro off: div 100/7 → `done` after edge 1, `result`=0, `error`=1.
